car_addr_scheduler: RTL and testbench

//  Sequencer/arbiter for the five Counter Address Registers (PCRA0, PCRA1, SP, SI, DI); drives all their strobes.

---
 rtl/car_addr_if.sv | 32 +++
 rtl/car_addr_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_car_addr_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/car_addr_if.sv
// Handshake and strobe bundle between the CAR scheduler and its requesters / CAR bank.
interface car_addr_if;
  logic [3:0] req;
  logic       stack_pop;
  logic       si_dir;
  logic       di_dir;
  logic [3:0] gnt;
  logic       pc_swap;
  logic       active_pc;
  logic       xfer_valid;
  logic [2:0] xfer_sel;
  logic       xfer_dir;
  logic       xfer_ready;
  logic       xfer_err;
  logic [4:0] car_addr_n;
  logic [4:0] car_xload_n;
  logic [4:0] car_xassert_n;
  logic [4:0] car_inc;
  logic [4:0] car_dec;

  modport master (
    output req, stack_pop, si_dir, di_dir, pc_swap, xfer_valid, xfer_sel, xfer_dir,
    input  gnt, active_pc, xfer_ready, xfer_err,
           car_addr_n, car_xload_n, car_xassert_n, car_inc, car_dec
  );

  modport slave (
    input  req, stack_pop, si_dir, di_dir, pc_swap, xfer_valid, xfer_sel, xfer_dir,
    output gnt, active_pc, xfer_ready, xfer_err,
           car_addr_n, car_xload_n, car_xassert_n, car_inc, car_dec
  );
endinterface

// File: rtl/car_addr_scheduler.sv
// Arbitrates the Addr bus among fetch/stack/SI/DI, sequences pops, tracks the live PC
// and schedules Xbus transfers onto the five Counter Address Registers.
module car_addr_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter bit PC_RESET_SEL = 1'b0
) (
  input logic       clock,
  input logic       clear,
  car_addr_if.slave bus
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {ARB, POP_PRE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [4:0]    addr_n_q, addr_n_d;
  logic [4:0]    xload_n_q, xload_n_d;
  logic [4:0]    xassert_n_q, xassert_n_d;
  logic [4:0]    inc_q, inc_d;
  logic [4:0]    dec_q, dec_d;
  logic          err_q, err_d;
  logic          active_pc_q, active_pc_d;
  logic          swap_pend_q, swap_pend_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    last_nf_q, last_nf_d;
  logic          en_q;

  logic [3:0] nf_req;
  logic [1:0] win;
  logic       win_vld;
  logic       pop_win;
  logic [1:0] rr_idx;
  logic       rr_found;
  logic [2:0] addr_tgt;
  logic       addr_tgt_vld;
  logic       swap_eff;
  logic       xfer_ok;

  // A non-fetch requester keeps req high through its own grant cycle; masking it
  // with gnt_q stops that stale level from winning a second time.
  always_comb begin
    nf_req   = {bus.req[3:1] & ~gnt_q[3:1], 1'b0};
    win      = 2'd0;
    win_vld  = 1'b0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    if (state_q == ARB) begin
      if ((starve_q == STARVE_MAX) && (|nf_req)) begin
        for (int i = 1; i <= 3; i++) begin
          rr_idx = 2'(((int'(last_nf_q) - 1 + i) % 3) + 1);
          if (!rr_found && nf_req[rr_idx]) begin
            win      = rr_idx;
            win_vld  = 1'b1;
            rr_found = 1'b1;
          end
        end
      end else if (bus.req[0]) begin
        win = 2'd0; win_vld = 1'b1;
      end else if (nf_req[1]) begin
        win = 2'd1; win_vld = 1'b1;
      end else if (nf_req[2]) begin
        win = 2'd2; win_vld = 1'b1;
      end else if (nf_req[3]) begin
        win = 2'd3; win_vld = 1'b1;
      end
    end
    pop_win = win_vld && (win == 2'd1) && bus.stack_pop;
  end

  // The PC may only flip on an edge that does not close a fetch grant cycle.
  always_comb begin
    swap_eff = swap_pend_q ^ bus.pc_swap;
    if (gnt_q[0]) begin
      active_pc_d = active_pc_q;
      swap_pend_d = swap_eff;
    end else begin
      active_pc_d = active_pc_q ^ swap_eff;
      swap_pend_d = 1'b0;
    end
  end

  always_comb begin
    case (win)
      2'd0:    addr_tgt = {2'b00, active_pc_d};
      2'd1:    addr_tgt = 3'd2;
      2'd2:    addr_tgt = 3'd3;
      default: addr_tgt = 3'd4;
    endcase
    addr_tgt_vld = win_vld && !pop_win;
  end

  assign bus.xfer_ready = en_q && (state_q == ARB)
                        && !(addr_tgt_vld && (bus.xfer_sel == addr_tgt))
                        && !(pop_win && (bus.xfer_sel == 3'd2));
  assign xfer_ok = bus.xfer_valid && bus.xfer_ready;

  always_comb begin
    state_d     = ARB;
    gnt_d       = 4'b0000;
    addr_n_d    = 5'b11111;
    inc_d       = 5'b00000;
    dec_d       = 5'b00000;
    xload_n_d   = 5'b11111;
    xassert_n_d = 5'b11111;
    err_d       = 1'b0;
    starve_d    = starve_q;
    last_nf_d   = last_nf_q;
    if (state_q == POP_PRE) begin
      gnt_d[1]    = 1'b1;
      addr_n_d[2] = 1'b0;
    end else if (win_vld) begin
      if (win == 2'd0) begin
        gnt_d[0]           = 1'b1;
        addr_n_d[addr_tgt] = 1'b0;
        inc_d[addr_tgt]    = 1'b1;
        if (|nf_req)
          starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + SW'(1);
      end else begin
        starve_d  = '0;
        last_nf_d = win;
        if (pop_win) begin
          state_d  = POP_PRE;
          inc_d[2] = 1'b1;
        end else begin
          gnt_d[win]         = 1'b1;
          addr_n_d[addr_tgt] = 1'b0;
          case (win)
            2'd1:    dec_d[2] = 1'b1;
            2'd2:    if (bus.si_dir) dec_d[3] = 1'b1; else inc_d[3] = 1'b1;
            default: if (bus.di_dir) dec_d[4] = 1'b1; else inc_d[4] = 1'b1;
          endcase
        end
      end
    end
    if (xfer_ok) begin
      if (bus.xfer_sel <= 3'd4) begin
        if (bus.xfer_dir) xassert_n_d[bus.xfer_sel] = 1'b0;
        else              xload_n_d[bus.xfer_sel]   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // last_nf resets to DI so the first starvation grant goes to the stack.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= ARB;
      gnt_q       <= 4'b0000;
      addr_n_q    <= 5'b11111;
      xload_n_q   <= 5'b11111;
      xassert_n_q <= 5'b11111;
      inc_q       <= 5'b00000;
      dec_q       <= 5'b00000;
      err_q       <= 1'b0;
      active_pc_q <= PC_RESET_SEL;
      swap_pend_q <= 1'b0;
      starve_q    <= '0;
      last_nf_q   <= 2'd3;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      addr_n_q    <= addr_n_d;
      xload_n_q   <= xload_n_d;
      xassert_n_q <= xassert_n_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      err_q       <= err_d;
      active_pc_q <= active_pc_d;
      swap_pend_q <= swap_pend_d;
      starve_q    <= starve_d;
      last_nf_q   <= last_nf_d;
      en_q        <= 1'b1;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.car_addr_n    = addr_n_q;
  assign bus.car_xload_n   = xload_n_q;
  assign bus.car_xassert_n = xassert_n_q;
  assign bus.car_inc       = inc_q;
  assign bus.car_dec       = dec_q;
  assign bus.xfer_err      = err_q;
  assign bus.active_pc     = active_pc_q;
endmodule

// File: tb/tb_car_addr_scheduler.sv
// Directed self-checking bench for car_addr_scheduler (STARVE_LIMIT=4, PC_RESET_SEL=0).
module tb_car_addr_scheduler;
  logic clock;
  logic clear;
  int   vecs = 0;
  int   errs = 0;

  car_addr_if bus();

  car_addr_scheduler #(.STARVE_LIMIT(4), .PC_RESET_SEL(1'b0)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.req = 4'b0000; bus.stack_pop = 1'b0; bus.si_dir = 1'b0; bus.di_dir = 1'b0;
    bus.pc_swap = 1'b0; bus.xfer_valid = 1'b0; bus.xfer_sel = 3'd0; bus.xfer_dir = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #2;
    vecs++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL rst_gnt got %b want 0000", bus.gnt); end
    vecs++; if (bus.car_addr_n !== 5'b11111) begin errs++; $display("FAIL rst_addr_n got %b want 11111", bus.car_addr_n); end
    vecs++; if (bus.car_xload_n !== 5'b11111) begin errs++; $display("FAIL rst_xload_n got %b want 11111", bus.car_xload_n); end
    vecs++; if (bus.car_xassert_n !== 5'b11111) begin errs++; $display("FAIL rst_xassert_n got %b want 11111", bus.car_xassert_n); end
    vecs++; if (bus.car_inc !== 5'b00000) begin errs++; $display("FAIL rst_inc got %b want 00000", bus.car_inc); end
    vecs++; if (bus.car_dec !== 5'b00000) begin errs++; $display("FAIL rst_dec got %b want 00000", bus.car_dec); end
    vecs++; if (bus.xfer_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b want 0", bus.xfer_ready); end
    vecs++; if (bus.xfer_err !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", bus.xfer_err); end
    vecs++; if (bus.active_pc !== 1'b0) begin errs++; $display("FAIL rst_active_pc got %b want 0", bus.active_pc); end
    clear = 1'b1;
    tick();
    vecs++; if (bus.xfer_ready !== 1'b1) begin errs++; $display("FAIL idle_ready got %b want 1", bus.xfer_ready); end
  endtask

  task automatic test_fetch();
    int incs = 0;
    bus.req = 4'b0001;
    tick();
    vecs++; if (bus.gnt !== 4'b0001) begin errs++; $display("FAIL fetch_gnt got %b want 0001", bus.gnt); end
    vecs++; if (bus.car_addr_n !== 5'b11110) begin errs++; $display("FAIL fetch_addr_n got %b want 11110", bus.car_addr_n); end
    vecs++; if (bus.car_inc !== 5'b00001) begin errs++; $display("FAIL fetch_inc got %b want 00001", bus.car_inc); end
    incs += int'(bus.car_inc[0]);
    tick(); incs += int'(bus.car_inc[0]);
    tick(); incs += int'(bus.car_inc[0]);
    bus.req = 4'b0000;
    tick();
    vecs++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL fetch_idle_gnt got %b want 0000", bus.gnt); end
    vecs++; if (incs != 3) begin errs++; $display("FAIL fetch_pcra0_steps got %0d want 3", incs); end
  endtask

  task automatic test_starve();
    logic [3:0] exp_gnt [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
    bus.req = 4'b1111; bus.stack_pop = 1'b0; bus.si_dir = 1'b0; bus.di_dir = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (bus.gnt !== exp_gnt[i]) begin errs++; $display("FAIL starve_gnt[%0d] got %b want %b", i, bus.gnt, exp_gnt[i]); end
      if (i == 4) begin
        vecs++; if (bus.car_addr_n !== 5'b11011) begin errs++; $display("FAIL push_addr_n got %b want 11011", bus.car_addr_n); end
        vecs++; if (bus.car_dec !== 5'b00100) begin errs++; $display("FAIL push_dec got %b want 00100", bus.car_dec); end
      end
      if (i == 9) begin
        vecs++; if (bus.car_addr_n !== 5'b10111) begin errs++; $display("FAIL si_addr_n got %b want 10111", bus.car_addr_n); end
        vecs++; if (bus.car_inc !== 5'b01000) begin errs++; $display("FAIL si_inc got %b want 01000", bus.car_inc); end
        bus.req = 4'b0000;
      end
    end
    tick();
    vecs++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL starve_end_gnt got %b want 0000", bus.gnt); end
  endtask

  task automatic test_pop();
    bus.req = 4'b0010; bus.stack_pop = 1'b1;
    tick();
    vecs++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL pop_pre_gnt got %b want 0000", bus.gnt); end
    vecs++; if (bus.car_inc !== 5'b00100) begin errs++; $display("FAIL pop_pre_inc got %b want 00100", bus.car_inc); end
    vecs++; if (bus.car_addr_n !== 5'b11111) begin errs++; $display("FAIL pop_pre_addr_n got %b want 11111", bus.car_addr_n); end
    bus.req = 4'b0011;
    #1;
    vecs++; if (bus.xfer_ready !== 1'b0) begin errs++; $display("FAIL pop_pre_ready got %b want 0", bus.xfer_ready); end
    tick();
    vecs++; if (bus.gnt !== 4'b0010) begin errs++; $display("FAIL pop_gnt got %b want 0010", bus.gnt); end
    vecs++; if (bus.car_addr_n !== 5'b11011) begin errs++; $display("FAIL pop_addr_n got %b want 11011", bus.car_addr_n); end
    vecs++; if ((bus.car_inc | bus.car_dec) !== 5'b00000) begin errs++; $display("FAIL pop_step got %b want 00000", bus.car_inc | bus.car_dec); end
    bus.req = 4'b0001; bus.stack_pop = 1'b0;
    tick();
    vecs++; if (bus.car_addr_n !== 5'b11110) begin errs++; $display("FAIL post_pop_fetch got %b want 11110", bus.car_addr_n); end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_swap();
    bus.req = 4'b0001;
    tick();
    bus.pc_swap = 1'b1; bus.req = 4'b0000;
    tick();
    vecs++; if (bus.active_pc !== 1'b0) begin errs++; $display("FAIL swap_pending_pc got %b want 0", bus.active_pc); end
    bus.pc_swap = 1'b0;
    tick();
    vecs++; if (bus.active_pc !== 1'b1) begin errs++; $display("FAIL swap_done_pc got %b want 1", bus.active_pc); end
    bus.req = 4'b0001;
    tick();
    vecs++; if (bus.car_addr_n !== 5'b11101) begin errs++; $display("FAIL swap_fetch_addr_n got %b want 11101", bus.car_addr_n); end
    vecs++; if (bus.car_inc !== 5'b00010) begin errs++; $display("FAIL swap_fetch_inc got %b want 00010", bus.car_inc); end
    bus.pc_swap = 1'b1;
    tick();
    tick();
    bus.pc_swap = 1'b0; bus.req = 4'b0000;
    tick();
    tick();
    vecs++; if (bus.active_pc !== 1'b1) begin errs++; $display("FAIL swap_cancel_pc got %b want 1", bus.active_pc); end
    bus.pc_swap = 1'b1;
    tick();
    bus.pc_swap = 1'b0;
    vecs++; if (bus.active_pc !== 1'b0) begin errs++; $display("FAIL swap_free_pc got %b want 0", bus.active_pc); end
  endtask

  task automatic test_xfer();
    bus.req = 4'b0100; bus.si_dir = 1'b1;
    bus.xfer_valid = 1'b1; bus.xfer_sel = 3'd3; bus.xfer_dir = 1'b0;
    #1;
    vecs++; if (bus.xfer_ready !== 1'b0) begin errs++; $display("FAIL xfer_si_clash_ready got %b want 0", bus.xfer_ready); end
    tick();
    vecs++; if (bus.car_addr_n !== 5'b10111) begin errs++; $display("FAIL xfer_si_addr_n got %b want 10111", bus.car_addr_n); end
    vecs++; if (bus.car_dec !== 5'b01000) begin errs++; $display("FAIL xfer_si_dec got %b want 01000", bus.car_dec); end
    vecs++; if (bus.car_xload_n !== 5'b11111) begin errs++; $display("FAIL xfer_si_xload_early got %b want 11111", bus.car_xload_n); end
    bus.req = 4'b0000;
    #1;
    vecs++; if (bus.xfer_ready !== 1'b1) begin errs++; $display("FAIL xfer_si_ready got %b want 1", bus.xfer_ready); end
    tick();
    vecs++; if (bus.car_xload_n !== 5'b10111) begin errs++; $display("FAIL xfer_si_xload got %b want 10111", bus.car_xload_n); end
    vecs++; if (bus.car_addr_n !== 5'b11111) begin errs++; $display("FAIL xfer_si_addr_idle got %b want 11111", bus.car_addr_n); end
    bus.req = 4'b0001; bus.xfer_sel = 3'd1; bus.xfer_dir = 1'b1;
    #1;
    vecs++; if (bus.xfer_ready !== 1'b1) begin errs++; $display("FAIL xfer_conc_ready got %b want 1", bus.xfer_ready); end
    tick();
    vecs++; if (bus.car_addr_n !== 5'b11110) begin errs++; $display("FAIL xfer_conc_addr_n got %b want 11110", bus.car_addr_n); end
    vecs++; if (bus.car_xassert_n !== 5'b11101) begin errs++; $display("FAIL xfer_conc_xassert got %b want 11101", bus.car_xassert_n); end
    vecs++; if (bus.car_xload_n !== 5'b11111) begin errs++; $display("FAIL xfer_xload_once got %b want 11111", bus.car_xload_n); end
    bus.xfer_sel = 3'd0;
    #1;
    vecs++; if (bus.xfer_ready !== 1'b0) begin errs++; $display("FAIL xfer_pc_clash_ready got %b want 0", bus.xfer_ready); end
    bus.xfer_valid = 1'b0; bus.req = 4'b0000;
    tick();
    vecs++; if (bus.car_xassert_n !== 5'b11111) begin errs++; $display("FAIL xfer_idle_xassert got %b want 11111", bus.car_xassert_n); end
  endtask

  task automatic test_xfer_err();
    bus.xfer_valid = 1'b1; bus.xfer_sel = 3'd6; bus.xfer_dir = 1'b0;
    #1;
    vecs++; if (bus.xfer_ready !== 1'b1) begin errs++; $display("FAIL err_ready got %b want 1", bus.xfer_ready); end
    tick();
    vecs++; if (bus.xfer_err !== 1'b1) begin errs++; $display("FAIL err_pulse got %b want 1", bus.xfer_err); end
    vecs++; if ({bus.car_xload_n, bus.car_xassert_n} !== 10'h3FF) begin errs++; $display("FAIL err_strobes got %b want 1111111111", {bus.car_xload_n, bus.car_xassert_n}); end
    bus.xfer_valid = 1'b0;
    tick();
    vecs++; if (bus.xfer_err !== 1'b0) begin errs++; $display("FAIL err_clear got %b want 0", bus.xfer_err); end
  endtask

  task automatic test_reset_mid_pop();
    bus.pc_swap = 1'b1;
    tick();
    bus.pc_swap = 1'b0;
    vecs++; if (bus.active_pc !== 1'b1) begin errs++; $display("FAIL rmp_pc_set got %b want 1", bus.active_pc); end
    bus.req = 4'b0010; bus.stack_pop = 1'b1;
    tick();
    vecs++; if (bus.car_inc !== 5'b00100) begin errs++; $display("FAIL rmp_pre_inc got %b want 00100", bus.car_inc); end
    #2;
    clear = 1'b0;
    #1;
    vecs++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL rmp_gnt got %b want 0000", bus.gnt); end
    vecs++; if (bus.car_inc !== 5'b00000) begin errs++; $display("FAIL rmp_inc got %b want 00000", bus.car_inc); end
    vecs++; if (bus.car_addr_n !== 5'b11111) begin errs++; $display("FAIL rmp_addr_n got %b want 11111", bus.car_addr_n); end
    vecs++; if (bus.active_pc !== 1'b0) begin errs++; $display("FAIL rmp_pc got %b want 0", bus.active_pc); end
    vecs++; if (bus.xfer_ready !== 1'b0) begin errs++; $display("FAIL rmp_ready got %b want 0", bus.xfer_ready); end
    bus.req = 4'b0000; bus.stack_pop = 1'b0;
    #3;
    clear = 1'b1;
    tick();
    tick();
    vecs++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL rmp_after_gnt got %b want 0000", bus.gnt); end
    vecs++; if (bus.car_addr_n !== 5'b11111) begin errs++; $display("FAIL rmp_after_addr_n got %b want 11111", bus.car_addr_n); end
    vecs++; if ((bus.car_inc | bus.car_dec) !== 5'b00000) begin errs++; $display("FAIL rmp_after_step got %b want 00000", bus.car_inc | bus.car_dec); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starve();
    test_pop();
    test_swap();
    test_xfer();
    test_xfer_err();
    test_reset_mid_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
